// File: rtl/maze_loader.sv
// Maze map loader: streams a 10-word map from ROM into row storage,
// decodes start/end cells and answers registered open-cell queries.
module maze_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  output logic       rom_en,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       busy,
  output logic       done,
  output logic       map_valid,
  output logic [2:0] start_row,
  output logic [2:0] start_col,
  output logic [2:0] end_row,
  output logic [2:0] end_col,
  input  logic [2:0] q_row,
  input  logic [2:0] q_col,
  output logic       q_open
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       pv;
  logic [3:0] pa;
  logic [7:0] rows [8];
  logic [2:0] sr, sc, er, ec;
  logic       mv;
  logic       qr;

  always_comb begin
    state_nx = state;
    rom_en   = 1'b0;
    rom_addr = 4'd0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) state_nx = READ;
      end
      READ: begin
        rom_en   = 1'b1;
        rom_addr = cnt;
        busy     = 1'b1;
        if (cnt == 4'd9) state_nx = DRAIN;
      end
      DRAIN: begin
        busy     = 1'b1;
        state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      pv    <= 1'b0;
      pa    <= 4'd0;
      mv    <= 1'b0;
      qr    <= 1'b0;
      sr    <= 3'd0;
      sc    <= 3'd0;
      er    <= 3'd0;
      ec    <= 3'd0;
      for (int i = 0; i < 8; i++) rows[i] <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= (state == READ) ? cnt + 4'd1 : 4'd0;
      // ROM data lags the address by one cycle
      pv    <= rom_en;
      pa    <= rom_addr;
      if (state == IDLE && load)
        mv <= 1'b0;
      else if (state == DRAIN)
        mv <= 1'b1;
      if (pv) begin
        if (!pa[3])
          rows[pa[2:0]] <= rom_data;
        else if (!pa[0])
          {sr, sc} <= rom_data[5:0];
        else
          {er, ec} <= rom_data[5:0];
      end
      qr <= mv & rows[q_row][~q_col];
    end
  end

  // gate with live valid so a reload hides stale answers at once
  assign q_open    = qr & mv;
  assign map_valid = mv;
  assign start_row = sr;
  assign start_col = sc;
  assign end_row   = er;
  assign end_col   = ec;

endmodule

// File: doc/maze_loader.md
MAZE_LOADER -- requirements
Module: maze_loader

Interface
REQ-001 SHALL provide port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL provide port rst_n  input  1  reset; asynchronous and active-low.
REQ-003 SHALL provide port load  input  1  load request; sampled high in IDLE starts a map load.
REQ-004 SHALL provide port rom_en  output  1  read enable to the map ROM.
REQ-005 SHALL provide port rom_addr  output  4  read address to the map ROM.
REQ-006 SHALL provide port rom_data  input  8  ROM read data; valid the cycle after rom_en/rom_addr.
REQ-007 SHALL provide port busy  output  1  high while a load is in progress.
REQ-008 SHALL provide port done  output  1  one-cycle pulse on load completion.
REQ-009 SHALL provide port map_valid  output  1  high while the stored map is complete and usable.
REQ-010 SHALL provide ports start_row, start_col, end_row, end_col  output  3 each  decoded start and end cells.
REQ-011 SHALL provide ports q_row, q_col  input  3 each  cell query coordinates.
REQ-012 SHALL provide port q_open  output  1  query result; 1 = open cell.

Function
REQ-013 SHALL implement FSM states IDLE, READ, DRAIN, FIN.
REQ-014 In IDLE with load=1 at edge ending cycle T, SHALL enter READ, clear map_valid, and set busy=1 from cycle T+1.
REQ-015 In READ, SHALL drive rom_en=1 and rom_addr=k during cycle T+1+k, for k=0..9, in that order with no gaps.
REQ-016 SHALL capture rom_data at the edge ending cycle T+2+k as the word for address k, using a one-cycle-delayed address/valid pipeline.
REQ-017 After address 9 is issued, SHALL enter DRAIN for one cycle (T+11) with rom_en=0, capturing word 9.
REQ-018 In FIN (cycle T+12), SHALL drive done=1, busy=0, and map_valid=1, then return to IDLE; map_valid SHALL stay 1 until the next load or reset.
REQ-019 Outside READ, rom_en SHALL be 0 and rom_addr SHALL be 0.
REQ-020 Words 0..7 SHALL be stored as map rows 0..7; column c of a row SHALL be bit (7-c), with 1 = open.
REQ-021 Word 8 SHALL give start_row=bits[5:3] and start_col=bits[2:0]; word 9 SHALL give end_row/end_col in the same layout; bits[7:6] SHALL be ignored.
REQ-022 start_*/end_* SHALL update only at capture and hold otherwise.
REQ-023 q_open SHALL be registered with 1-cycle latency: q_open(n+1) = map_valid(n) & row[q_row(n)][7-q_col(n)].
REQ-024 While map_valid=0, including during a reload, q_open SHALL be 0.
REQ-025 load asserted while busy or in FIN SHALL be ignored; no queuing.
REQ-026 A held-high load SHALL start a new load on each return to IDLE; a new load overwrites all stored words.

Reset
REQ-027 When rst_n=0, SHALL asynchronously force the FSM to IDLE.
REQ-028 When rst_n=0, SHALL clear all map rows and start/end registers to 0, and drive rom_en, rom_addr, busy, done, map_valid, q_open and all coordinate outputs to 0.
REQ-029 Reset asserted mid-load SHALL abort the load; after release, map_valid SHALL remain 0 until a complete load finishes.

Verification
REQ-030 Basic load: ROM model words 0..9 = 3F,61,4D,E5,B7,11,F7,8C,38,07; pulse load at T -> rom_addr 0..9 on T+1..T+10, done high only at T+12, start=(7,0), end=(0,7), map_valid=1.
REQ-031 Query after the basic load: (0,7) -> q_open=1; (0,0) -> 0; (7,0) -> 1; (5,3) -> 1; (5,0) -> 0; each result appears one cycle after the query.
REQ-032 Reserved bits: word 8 = C0 -> start=(0,0); word 9 = FF -> end=(7,7).
REQ-033 Busy load: load pulsed at T+4 during a load -> address sequence unchanged, exactly one done pulse.
REQ-034 Reset mid-load: rst_n low at T+5 -> all outputs 0 immediately; a fresh load completes normally.
REQ-035 Reload: second load with ROM words changed -> map_valid=0 and q_open=0 from T+1; new contents are visible after done.
